// File: rtl/tube_scan_ctrl.sv
// tube_scan_ctrl: memory-mapped controller for the board's three digital-tube groups.
//
// Holds a CPU-writable 32-bit VALUE register and an 8-bit CTRL register. The eight hex
// digits of VALUE are time-multiplexed over tube groups 0 and 1 (four positions each).
// Group 2 shows the single status digit held in CTRL[7:4].
//
// Ports:
//   CLK_IN1            system clock; all state changes on its rising edge
//   reset              synchronous, active-low reset
//   we, addr, wdata    bridge write port (addr 0 = VALUE, addr 1 = CTRL)
//   rdata              combinational readback of the addressed register
//   digital_tube_sel0  one-hot, active-high position select, group 0
//   digital_tube_sel1  one-hot, active-high position select, group 1
//   digital_tube_sel2  active-high enable, group 2
//   digital_tube0..2   active-low segments {dp,g,f,e,d,c,b,a}; dp is always off
//
// CTRL layout: bit0 EN, bit1 LZ (leading-zero blanking), bits[3:2] reserved (read 0),
// bits[7:4] D2 (digit shown on group 2).

module tube_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        CLK_IN1,
    input  logic        reset,
    input  logic        we,
    input  logic        addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [3:0]  digital_tube_sel0,
    output logic [3:0]  digital_tube_sel1,
    output logic        digital_tube_sel2,
    output logic [7:0]  digital_tube0,
    output logic [7:0]  digital_tube1,
    output logic [7:0]  digital_tube2
);

    localparam int unsigned     DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [31:0]      value_q;
    logic [7:0]       ctrl_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       idx_q;

    logic [3:0] sel0_q, sel1_q;
    logic       sel2_q;
    logic [7:0] tube0_q, tube1_q, tube2_q;

    logic [3:0] sel0_d, sel1_d;
    logic       sel2_d;
    logic [7:0] tube0_d, tube1_d, tube2_d;
    logic       div_wrap;

    // Hex digit to active-low segment pattern, dp off.
    function automatic logic [7:0] seg(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Digit k is a leading zero when every nibble from k upward is zero.
    // Digit 0 is never blanked so a zero value still shows "0".
    function automatic logic is_leading_zero(input logic [31:0] v, input logic [2:0] k);
        logic lead;
        if (k == 3'd0) begin
            lead = 1'b0;
        end else begin
            lead = ((v >> {k, 2'b00}) == 32'd0);
        end
        return lead;
    endfunction

    // Segment pattern for global digit k, honouring LZ blanking.
    function automatic logic [7:0] digit_seg(input logic [31:0] v, input logic [2:0] k,
                                             input logic lz);
        logic [7:0] s;
        if (lz && is_leading_zero(v, k)) begin
            s = 8'hFF;
        end else begin
            s = seg(v[{k, 2'b00} +: 4]);
        end
        return s;
    endfunction

    assign div_wrap = (div_q == DIV_LAST);

    // Readback: reserved CTRL bits are never stored, so they read 0.
    assign rdata = addr ? {24'b0, ctrl_q} : value_q;

    // Next display state from the current index and registers.
    always_comb begin
        sel0_d  = 4'b0000;
        sel1_d  = 4'b0000;
        sel2_d  = 1'b0;
        tube0_d = 8'hFF;
        tube1_d = 8'hFF;
        tube2_d = 8'hFF;
        if (ctrl_q[0]) begin
            sel0_d  = 4'b0001 << idx_q;
            sel1_d  = 4'b0001 << idx_q;
            sel2_d  = 1'b1;
            tube0_d = digit_seg(value_q, {1'b0, idx_q}, ctrl_q[1]);
            tube1_d = digit_seg(value_q, {1'b1, idx_q}, ctrl_q[1]);
            tube2_d = seg(ctrl_q[7:4]);
        end
    end

    always_ff @(posedge CLK_IN1) begin
        if (!reset) begin
            value_q <= 32'd0;
            ctrl_q  <= 8'h01;
            div_q   <= '0;
            idx_q   <= 2'd0;
            sel0_q  <= 4'b0000;
            sel1_q  <= 4'b0000;
            sel2_q  <= 1'b0;
            tube0_q <= 8'hFF;
            tube1_q <= 8'hFF;
            tube2_q <= 8'hFF;
        end else begin
            // Divider and index run free; writes never disturb them.
            if (div_wrap) begin
                div_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                div_q <= div_q + 1'b1;
            end

            if (we) begin
                if (addr) begin
                    ctrl_q <= {wdata[7:4], 2'b00, wdata[1:0]};
                end else begin
                    value_q <= wdata;
                end
            end

            sel0_q  <= sel0_d;
            sel1_q  <= sel1_d;
            sel2_q  <= sel2_d;
            tube0_q <= tube0_d;
            tube1_q <= tube1_d;
            tube2_q <= tube2_d;
        end
    end

    assign digital_tube_sel0 = sel0_q;
    assign digital_tube_sel1 = sel1_q;
    assign digital_tube_sel2 = sel2_q;
    assign digital_tube0     = tube0_q;
    assign digital_tube1     = tube1_q;
    assign digital_tube2     = tube2_q;

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// Self-checking bench for tube_scan_ctrl with a short scan divider.
// The driver updates a behavioural model after each clock edge and queues the expected
// pins; a separate monitor pops one entry per cycle and compares it against the DUT.

module tb_tube_scan_ctrl;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic        addr = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic [3:0]  sel0, sel1;
    logic        sel2;
    logic [7:0]  tube0, tube1, tube2;

    tube_scan_ctrl #(.SCAN_DIV(DIV)) dut (
        .CLK_IN1          (clk),
        .reset            (reset),
        .we               (we),
        .addr             (addr),
        .wdata            (wdata),
        .rdata            (rdata),
        .digital_tube_sel0(sel0),
        .digital_tube_sel1(sel1),
        .digital_tube_sel2(sel2),
        .digital_tube0    (tube0),
        .digital_tube1    (tube1),
        .digital_tube2    (tube2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  sel0;
        logic [3:0]  sel1;
        logic        sel2;
        logic [7:0]  t0;
        logic [7:0]  t1;
        logic [7:0]  t2;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Model: register contents and count of non-reset edges since the last reset.
    logic [31:0] m_value = 32'd0;
    logic [7:0]  m_ctrl = 8'h01;
    int unsigned m_cyc = 0;

    int checks = 0;
    int errors = 0;

    // What the display should show for a given scan position and register contents.
    function automatic exp_t display(int unsigned cyc, logic [31:0] v, logic [7:0] c);
        exp_t e;
        int unsigned i;
        int unsigned k;
        logic [7:0] s;
        e = '0;
        e.t0 = 8'hFF;
        e.t1 = 8'hFF;
        e.t2 = 8'hFF;
        if (c[0]) begin
            i = (cyc / DIV) % 4;
            e.sel0 = 4'(1 << i);
            e.sel1 = 4'(1 << i);
            e.sel2 = 1'b1;
            for (int g = 0; g < 2; g++) begin
                k = i + 4 * g;
                if (c[1] && k >= 1 && (v >> (4 * k)) == 32'd0) s = 8'hFF;
                else s = seg_tab[(v >> (4 * k)) & 32'hF];
                if (g == 0) e.t0 = s;
                else e.t1 = s;
            end
            e.t2 = seg_tab[c[7:4]];
        end
        return e;
    endfunction

    // One clock edge with the given inputs; model and expectation follow the edge.
    task automatic tick(input logic r, input logic w, input logic a, input logic [31:0] d);
        exp_t e;
        reset = r;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        if (!r) begin
            m_value = 32'd0;
            m_ctrl  = 8'h01;
            m_cyc   = 0;
            e = '0;
            e.t0 = 8'hFF;
            e.t1 = 8'hFF;
            e.t2 = 8'hFF;
        end else begin
            e = display(m_cyc, m_value, m_ctrl);
            if (w) begin
                if (a) m_ctrl = d[7:0] & 8'hF3;
                else m_value = d;
            end
            m_cyc++;
        end
        e.rdata = a ? {24'd0, m_ctrl} : m_value;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom);
    endtask

    task automatic wr(input logic a, input logic [31:0] d);
        tick(1'b1, 1'b1, a, d);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a fresh output set.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sel0", 32'(sel0), 32'(e.sel0));
                chk("sel1", 32'(sel1), 32'(e.sel1));
                chk("sel2", 32'(sel2), 32'(e.sel2));
                chk("tube0", 32'(tube0), 32'(e.t0));
                chk("tube1", 32'(tube1), 32'(e.t1));
                chk("tube2", 32'(tube2), 32'(e.t2));
                chk("rdata", rdata, e.rdata);
            end
        end
    end

    initial begin
        // Reset for three cycles reading CTRL, then free-run past a full index wrap.
        for (int j = 0; j < 3; j++) tick(1'b0, 1'b0, 1'b1, 32'd0);
        idle(20);

        wr(1'b0, 32'h89AB_CDEF);
        idle(18);

        wr(1'b1, 32'h0000_00A3);
        wr(1'b0, 32'h0000_0120);
        idle(18);

        wr(1'b0, 32'h0000_0000);
        idle(18);

        // Disable, keep scanning, then re-enable mid-scan.
        wr(1'b1, 32'h0000_0000);
        idle(7);
        wr(1'b1, 32'h0000_0001);
        idle(10);

        // Write landing on the divider wrap edge.
        while ((m_cyc % DIV) != DIV - 1) idle(1);
        wr(1'b0, 32'h1234_5678);
        idle(6);

        // Reset mid-scan while index 2 is about to be shown.
        while (((m_cyc / DIV) % 4) != 2) idle(1);
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        idle(10);

        // Randomised traffic: mostly enabled CTRL values, occasional resets.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] d;
            logic        a;
            int unsigned r;
            r = $urandom_range(0, 99);
            a = 1'($urandom_range(0, 1));
            d = $urandom;
            if ($urandom_range(0, 3) != 0) d = d & 32'h0000_FFFF;
            if ($urandom_range(0, 3) == 0) d = d & 32'h0000_00FF;
            if (a && $urandom_range(0, 4) != 0) d[0] = 1'b1;
            if (r == 0) tick(1'b0, 1'b0, a, d);
            else if (r < 25) tick(1'b1, 1'b1, a, d);
            else tick(1'b1, 1'b0, a, d);
        end

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tube_scan_ctrl.md
Name: tube_scan_ctrl

Overview:
Memory-mapped display controller that time-multiplexes the board's three digital-tube groups.
- Holds a CPU-writable 32-bit value register and an 8-bit control register.
- Scans the 8 hex digits of the value across tube groups 0 and 1, four positions each.
- Drives tube group 2 with a single status digit.
- Sits behind the bridge as a peripheral and feeds the top-level digital_tube_* pins directly.

Parameters:
SCAN_DIV, 50000, clock cycles each digit position stays lit; legal range 2 or more.

Ports:
CLK_IN1  in  1  system clock; all state changes on its rising edge.
reset  in  1  synchronous, active-low reset.
we  in  1  write enable from bridge.
addr  in  1  register select: 0 = VALUE, 1 = CTRL.
wdata  in  32  write data.
rdata  out  32  combinational readback of the addressed register.
digital_tube_sel0  out  4  one-hot, active-high position select for group 0.
digital_tube_sel1  out  4  one-hot, active-high position select for group 1.
digital_tube_sel2  out  1  active-high enable for group 2.
digital_tube0  out  8  segments for group 0, active-low; bit0=a … bit6=g, bit7=dp.
digital_tube1  out  8  segments for group 1, same encoding.
digital_tube2  out  8  segments for group 2, same encoding.

Behaviour:
- Reset (reset==0 at clock edge):
  - VALUE=0, CTRL=8'h01, divider=0, scan index=0.
  - All sel outputs 0; all segment outputs 8'hFF; dp is always off (bit7=1).
- CTRL fields:
  - bit0 EN.
  - bit1 LZ (leading-zero blanking).
  - bits[3:2] reserved: write ignored, read 0.
  - bits[7:4] D2 (hex digit shown on group 2).
- Writes:
  - we=1 at an edge loads wdata into VALUE (addr=0) or wdata[7:0] into CTRL (addr=1).
  - rdata: addr=0 returns VALUE; addr=1 returns {24'b0, CTRL with bits[3:2]=0}.
  - rdata reflects a write from the cycle after the write.
- Divider:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - On the wrap edge, scan index i advances 0→1→2→3→0.
  - The divider runs regardless of EN; register writes never reset it or the index.
- Outputs are registered and recomputed every cycle from the current index, VALUE and CTRL. A register write is therefore visible on the pins 2 edges after the write edge (1 edge to update the register, 1 to update the outputs).
- EN=1:
  - sel0 = sel1 = 4'b0001 << i; sel2 = 1.
  - tube0 = seg(VALUE[4i+3:4i]); tube1 = seg(VALUE[4i+19:4i+16]); tube2 = seg(D2).
- EN=0: all sel = 0, all segments = 8'hFF. Index and divider keep running.
- Global digit number k: k = i for group 0, k = i+4 for group 1.
- LZ=1: digit k (k≥1) is blanked (segments 8'hFF, sel still asserted) when VALUE[31:4k]==0. Digit 0 is never blanked, so VALUE=0 shows a single "0".
- seg table, digit 0 through F:
  - 0–7: C0 F9 A4 B0 99 92 82 F8.
  - 8–F: 80 90 88 83 C6 A1 86 8E.
- Simultaneous write and divider wrap on the same edge: both take effect. The next output update uses the new index and the new register value.
- Reset asserted mid-scan: returns everything to reset state on that edge. The first non-reset edge afterwards drives index 0.

Test Plan:
1. SCAN_DIV=4; hold reset=0 for 3 cycles, then release. During reset: sel0/sel1=0, tubes=FF, rdata(addr1)=32'h1. After release: sel0=0001 on the 1st edge, 0010 from edge 5 on, wrapping to 0001 after 16 cycles.
2. Write VALUE=32'h89AB_CDEF. At index 0: tube0=8E (F), tube1=80 (8)? No — tube1 shows digit 4 = B, so tube1=83. At index 3: tube0=C6 (C), tube1=80 (8). rdata(addr0)=32'h89ABCDEF.
3. Write CTRL=8'hA3 (EN, LZ, D2=A) and VALUE=32'h0000_0120.
   - Index 0: tube0=C0.
   - Index 1: tube0=A4.
   - Index 2: tube0=F9.
   - Index 3: tube0=FF.
   - Group 1: FF at all indices.
   - tube2=88, sel2=1.
   - rdata(addr1)=32'hA3.
4. LZ=1 with VALUE=0: only digit 0 lit (tube0=C0 at index 0); every other position is FF.
5. Write CTRL=8'h00: 2 edges later all sel=0 and tubes=FF. The index keeps advancing. Write CTRL=8'h01: display resumes at the current index, not index 0.
6. Issue a write on the same edge as a divider wrap, and separately assert reset mid-scan at index 2. The first case shows the new value at the new index. The second gives reset outputs, then index 0 after release.
